vga_timing: RTL and testbench

//  Generates 800x600@60 Hz VGA raster timing from one 40 MHz pixel clock.

---
 rtl/vga_timing_pkg.sv | 27 ++
 rtl/vga_timing_if.sv | 43 ++++
 rtl/vga_axis_counter.sv | 63 ++++++
 rtl/vga_timing.sv | 95 +++++++++
 tb/tb_vga_timing.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared timing constants and types for the 800x600@60 Hz raster generator.
// The optional pixel clock-enable is selected with VGA_TIMING_PIX_CE_EN.
package vga_timing_pkg;

  // Counter width: 11 bits holds every position up to H_TOT-1 = 1055 (< 2048).
  localparam int COUNT_W = 11;

  // Horizontal timing in pixels (800x600@60 Hz VESA, 40 MHz pixel clock).
  localparam int H_VIS  = 800;
  localparam int H_FP   = 40;
  localparam int H_SYNC = 128;
  localparam int H_TOT  = 1056;

  // Vertical timing in lines.
  localparam int V_VIS  = 600;
  localparam int V_FP   = 1;
  localparam int V_SYNC = 4;
  localparam int V_TOT  = 628;

  typedef logic [COUNT_W-1:0] count_t;

  // True when lo <= c < hi; used for the half-open sync windows.
  function automatic logic in_window(count_t c, count_t lo, count_t hi);
    return (c >= lo) && (c < hi);
  endfunction

endpackage : vga_timing_pkg

// File: rtl/vga_timing_if.sv
// Raster timing bundle between the timing generator (master) and the
// background-draw stage (slave). pix_ce exists only with VGA_TIMING_PIX_CE_EN.
interface vga_timing_if;
  import vga_timing_pkg::*;

`ifdef VGA_TIMING_PIX_CE_EN
  logic   pix_ce;        // pixel clock-enable from the clock domain owner
`endif
  count_t hcount_out;    // horizontal position, 0..H_TOT-1
  count_t vcount_out;    // vertical position, 0..V_TOT-1
  logic   hsync_out;     // active-high horizontal sync
  logic   hblnk_out;     // horizontal blanking
  logic   vsync_out;     // active-high vertical sync
  logic   vblnk_out;     // vertical blanking
  logic   frame_st_out;  // pulse on the cycle the raster wraps to (0,0)

  modport master (
`ifdef VGA_TIMING_PIX_CE_EN
    input  pix_ce,
`endif
    output hcount_out,
    output vcount_out,
    output hsync_out,
    output hblnk_out,
    output vsync_out,
    output vblnk_out,
    output frame_st_out
  );

  modport slave (
`ifdef VGA_TIMING_PIX_CE_EN
    output pix_ce,
`endif
    input  hcount_out,
    input  vcount_out,
    input  hsync_out,
    input  hblnk_out,
    input  vsync_out,
    input  vblnk_out,
    input  frame_st_out
  );

endinterface : vga_timing_if

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter with registered blanking and
// sync flags. Flags are derived from the next-state count so they land in the
// same register stage as the count itself (zero skew).
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOT  = H_TOT,   // positions per period, 0..TOT-1
  parameter int VIS  = H_VIS,   // visible positions
  parameter int FP   = H_FP,    // front porch length
  parameter int SYNC = H_SYNC   // sync pulse length
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   ce,
  output count_t cnt,
  output logic   blnk,
  output logic   sync,
  output logic   wrap
);

  localparam count_t LAST    = count_t'(TOT - 1);
  localparam count_t BLNK_LO = count_t'(VIS);
  localparam count_t SYNC_LO = count_t'(VIS + FP);
  localparam count_t SYNC_HI = count_t'(VIS + FP + SYNC);

  count_t cnt_q,  cnt_d;
  logic   blnk_q, blnk_d;
  logic   sync_q, sync_d;

  // Next position and the flags that position will carry.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    cnt_d  = cnt_q;
    if (ce) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
    blnk_d = (cnt_d >= BLNK_LO);
    sync_d = in_window(cnt_d, SYNC_LO, SYNC_HI);
  end

  // Count and flag registers with synchronous reset to the origin.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every register sample pre-edge
    // values, so the order of these statements carries no meaning.
    if (rst) begin
      cnt_q  <= '0;
      blnk_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      blnk_q <= blnk_d;
      sync_q <= sync_d;
    end
  end

  assign cnt  = cnt_q;
  assign blnk = blnk_q;
  assign sync = sync_q;
  // Terminal count: the next enabled step returns this axis to 0.
  assign wrap = (cnt_q == LAST);

endmodule : vga_axis_counter

// File: rtl/vga_timing.sv
// 800x600@60 Hz raster timing generator. Two axis counters (horizontal steps
// every enabled pixel, vertical steps on horizontal wrap) plus a frame-start
// pulse. All outputs are registered and mutually aligned.
// Optional feature: define VGA_TIMING_PIX_CE_EN to gate advancement with
// pix_ce; otherwise the raster advances on every clock edge.
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int H_VIS_P  = H_VIS,
  parameter int H_FP_P   = H_FP,
  parameter int H_SYNC_P = H_SYNC,
  parameter int H_TOT_P  = H_TOT,
  parameter int V_VIS_P  = V_VIS,
  parameter int V_FP_P   = V_FP,
  parameter int V_SYNC_P = V_SYNC,
  parameter int V_TOT_P  = V_TOT
) (
  input  logic         clk,
  input  logic         rst,
  vga_timing_if.master vga
);

  logic   pix_en;
  logic   h_wrap, v_wrap, v_ce;
  count_t hcount, vcount;
  logic   hblnk, hsync, vblnk, vsync;
  logic   frame_st_q, frame_st_d;

`ifdef VGA_TIMING_PIX_CE_EN
  assign pix_en = vga.pix_ce;
`else
  assign pix_en = 1'b1;
`endif

  // Vertical advances only on an enabled edge that wraps the line.
  assign v_ce = pix_en & h_wrap;

  vga_axis_counter #(
    .TOT  (H_TOT_P),
    .VIS  (H_VIS_P),
    .FP   (H_FP_P),
    .SYNC (H_SYNC_P)
  ) u_h_axis (
    .clk  (clk),
    .rst  (rst),
    .ce   (pix_en),
    .cnt  (hcount),
    .blnk (hblnk),
    .sync (hsync),
    .wrap (h_wrap)
  );

  vga_axis_counter #(
    .TOT  (V_TOT_P),
    .VIS  (V_VIS_P),
    .FP   (V_FP_P),
    .SYNC (V_SYNC_P)
  ) u_v_axis (
    .clk  (clk),
    .rst  (rst),
    .ce   (v_ce),
    .cnt  (vcount),
    .blnk (vblnk),
    .sync (vsync),
    .wrap (v_wrap)
  );

  // Frame start: set when the raster steps from the last pixel of the last
  // line to (0,0); a disabled edge holds the current value.
  always_comb begin
    frame_st_d = frame_st_q;
    if (pix_en) begin
      frame_st_d = h_wrap & v_wrap;
    end
  end

  // Frame-start register; reset leaves it low so the post-reset origin is
  // not mistaken for a wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_st_q <= 1'b0;
    end else begin
      frame_st_q <= frame_st_d;
    end
  end

  assign vga.hcount_out   = hcount;
  assign vga.vcount_out   = vcount;
  assign vga.hsync_out    = hsync;
  assign vga.hblnk_out    = hblnk;
  assign vga.vsync_out    = vsync;
  assign vga.vblnk_out    = vblnk;
  assign vga.frame_st_out = frame_st_q;

endmodule : vga_timing

// File: tb/tb_vga_timing.sv
// Bench for vga_timing. A full-size 800x600 instance covers reset and line
// boundaries; a shrunken-geometry instance (26x11) covers frame-level
// behaviour within a short run. A reference model pushes the expected
// registered outputs of each instance every clock; a monitor pops and
// compares on the falling edge. Directed checks cover the called-out
// boundaries. Define VGA_TIMING_PIX_CE_EN to exercise the clock-enable.
module tb_vga_timing;
  import vga_timing_pkg::*;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        hb;
    logic        vs;
    logic        vb;
    logic        fs;
  } obs_t;

  // Window boundaries per geometry, hand-derived.
  typedef struct {
    int ht, hb, hs0, hs1, vt, vb, vs0, vs1;
  } geo_t;

  geo_t g_f = '{1056, 800, 840, 968, 628, 600, 601, 605};
  geo_t g_s = '{26, 16, 18, 22, 11, 6, 7, 9};

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic pix_ce = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  obs_t q_f[$];
  obs_t q_s[$];
  obs_t m_f = '0;
  obs_t m_s = '0;

  always #5 clk = ~clk;

  vga_timing_if vif_f ();
  vga_timing_if vif_s ();

`ifdef VGA_TIMING_PIX_CE_EN
  assign vif_f.pix_ce = pix_ce;
  assign vif_s.pix_ce = pix_ce;
`endif

  vga_timing dut_f (
    .clk (clk),
    .rst (rst),
    .vga (vif_f)
  );

  vga_timing #(
    .H_VIS_P (16), .H_FP_P (2), .H_SYNC_P (4), .H_TOT_P (26),
    .V_VIS_P (6),  .V_FP_P (1), .V_SYNC_P (2), .V_TOT_P (11)
  ) dut_s (
    .clk (clk),
    .rst (rst),
    .vga (vif_s)
  );

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one clock edge of the raster.
  function automatic obs_t model_step(obs_t c, logic r, logic en, geo_t g);
    obs_t n;
    int   h;
    int   v;
    n = c;
    if (r) return '0;
    if (!en) return c;
    h = int'(c.h);
    v = int'(c.v);
    n.fs = (h == g.ht - 1) && (v == g.vt - 1);
    if (h == g.ht - 1) begin
      h = 0;
      v = (v == g.vt - 1) ? 0 : v + 1;
    end else begin
      h = h + 1;
    end
    n.h  = 11'(h);
    n.v  = 11'(v);
    n.hb = (h >= g.hb);
    n.hs = (h >= g.hs0) && (h < g.hs1);
    n.vb = (v >= g.vb);
    n.vs = (v >= g.vs0) && (v < g.vs1);
    return n;
  endfunction

  function automatic obs_t pack_obs(logic [10:0] h, logic [10:0] v, logic hs,
                                    logic hb, logic vs, logic vb, logic fs);
    obs_t o;
    o.h = h; o.v = v; o.hs = hs; o.hb = hb; o.vs = vs; o.vb = vb; o.fs = fs;
    return o;
  endfunction

  // Expected-value producer: one entry per DUT per clock edge.
  always @(posedge clk) begin
    m_f = model_step(m_f, rst, pix_ce, g_f);
    m_s = model_step(m_s, rst, pix_ce, g_s);
    q_f.push_back(m_f);
    q_s.push_back(m_s);
  end

  // Monitor: compare the registered outputs each cycle, away from the edge.
  always @(negedge clk) begin
    obs_t a;
    obs_t e;
    if (q_f.size() > 0) begin
      e = q_f.pop_front();
      a = pack_obs(vif_f.hcount_out, vif_f.vcount_out, vif_f.hsync_out,
                   vif_f.hblnk_out, vif_f.vsync_out, vif_f.vblnk_out, vif_f.frame_st_out);
      check("sb_full", int'(a), int'(e));
    end
    if (q_s.size() > 0) begin
      e = q_s.pop_front();
      a = pack_obs(vif_s.hcount_out, vif_s.vcount_out, vif_s.hsync_out,
                   vif_s.hblnk_out, vif_s.vsync_out, vif_s.vblnk_out, vif_s.frame_st_out);
      check("sb_small", int'(a), int'(e));
    end
  end

  initial begin
    int   guard;
    int   nhs, first_hs, last_hs, first_hb;
    int   period, nvb, nvs;
    obs_t a;

    // 1: reset held for 5 cycles.
    rst    = 1'b1;
    pix_ce = 1'b1;
    repeat (5) @(negedge clk);
    a = pack_obs(vif_f.hcount_out, vif_f.vcount_out, vif_f.hsync_out,
                 vif_f.hblnk_out, vif_f.vsync_out, vif_f.vblnk_out, vif_f.frame_st_out);
    check("rst_all_zero_full", int'(a), 0);
    rst = 1'b0;
    @(negedge clk);
    check("first_hcount", int'(vif_f.hcount_out), 1);
    check("first_vcount", int'(vif_f.vcount_out), 0);
    check("first_frame_st", int'(vif_f.frame_st_out), 0);

    // 2: one line, recording where blanking and sync start and end.
    nhs = 0; first_hs = -1; last_hs = -1; first_hb = -1; guard = 0;
    while (int'(vif_f.hcount_out) != 1055 && guard < 1100) begin
      if (vif_f.hsync_out) begin
        nhs++;
        if (first_hs < 0) first_hs = int'(vif_f.hcount_out);
        last_hs = int'(vif_f.hcount_out);
      end
      if (vif_f.hblnk_out && first_hb < 0) first_hb = int'(vif_f.hcount_out);
      @(negedge clk);
      guard++;
    end
    check("line_end_reached", int'(guard < 1100), 1);
    check("hblnk_rise_h", first_hb, 800);
    check("hsync_width", nhs, 128);
    check("hsync_first_h", first_hs, 840);
    check("hsync_last_h", last_hs, 967);
    check("v_before_wrap", int'(vif_f.vcount_out), 0);
    @(negedge clk);
    check("h_after_wrap", int'(vif_f.hcount_out), 0);
    check("v_after_wrap", int'(vif_f.vcount_out), 1);
    check("hblnk_after_wrap", int'(vif_f.hblnk_out), 0);

    // 3: frame-level behaviour on the small geometry (26 x 11 = 286 cycles).
    guard = 0;
    while (!vif_s.frame_st_out && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    check("frame_st_seen", int'(guard < 400), 1);
    check("frame_st_origin", int'({vif_s.hcount_out, vif_s.vcount_out}), 0);
    period = 0; nvb = 0; nvs = 0;
    do begin
      @(negedge clk);
      period++;
      if (period == 1) check("frame_st_width", int'(vif_s.frame_st_out), 0);
      if (!vif_s.frame_st_out) begin
        nvb += int'(vif_s.vblnk_out);
        nvs += int'(vif_s.vsync_out);
      end
    end while (!vif_s.frame_st_out && period < 1000);
    check("frame_period", period, 286);
    check("vblnk_cycles", nvb, 130);
    check("vsync_cycles", nvs, 52);

    // 4: one-cycle reset mid-line aborts and restarts the raster.
    guard = 0;
    while (int'(vif_f.hcount_out) != 500 && guard < 1100) begin
      @(negedge clk);
      guard++;
    end
    check("mid_line_reached", int'(guard < 1100), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    a = pack_obs(vif_f.hcount_out, vif_f.vcount_out, vif_f.hsync_out,
                 vif_f.hblnk_out, vif_f.vsync_out, vif_f.vblnk_out, vif_f.frame_st_out);
    check("midrst_full_zero", int'(a), 0);
    a = pack_obs(vif_s.hcount_out, vif_s.vcount_out, vif_s.hsync_out,
                 vif_s.hblnk_out, vif_s.vsync_out, vif_s.vblnk_out, vif_s.frame_st_out);
    check("midrst_small_zero", int'(a), 0);
    @(negedge clk);
    check("midrst_restart_h", int'(vif_f.hcount_out), 1);
    check("midrst_restart_fs", int'(vif_s.frame_st_out), 0);

`ifdef VGA_TIMING_PIX_CE_EN
    // 5: alternating pix_ce halves the advance rate; frame takes 572 clocks.
    guard = 0;
    while (guard < 2000) begin
      @(negedge clk);
      guard++;
      if (vif_s.frame_st_out && int'(vif_s.hcount_out) == 0) break;
      pix_ce = ~pix_ce;
    end
    check("ce_first_frame", int'(guard < 2000), 1);
    period = 0;
    // Skip the stretched pulse, then count to the next rising edge.
    while (period < 2000) begin
      pix_ce = ~pix_ce;
      @(negedge clk);
      period++;
      if (!vif_s.frame_st_out) break;
    end
    while (period < 2000) begin
      pix_ce = ~pix_ce;
      @(negedge clk);
      period++;
      if (vif_s.frame_st_out) break;
    end
    check("ce_frame_period", period, 572);
    // Hold pix_ce low at (0,0): frame_st_out and counts must hold.
    pix_ce = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("ce_hold_frame_st", int'(vif_s.frame_st_out), 1);
      check("ce_hold_origin", int'({vif_s.hcount_out, vif_s.vcount_out}), 0);
    end
    pix_ce = 1'b1;
    @(negedge clk);
    check("ce_release_fs", int'(vif_s.frame_st_out), 0);
    check("ce_release_h", int'(vif_s.hcount_out), 1);
`endif

    // 6: free run so the scoreboard covers more than two small frames.
    pix_ce = 1'b1;
    repeat (700) @(negedge clk);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_vga_timing
